// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encoding and counter-width helper shared by the serial adder files
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/a/b request and busy/done/sum/carry_out result bundle; master drives requests, slave is the adder
interface serial_adder_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] sum;
  logic carry_out;
  modport master (output start, a, b, input busy, done, sum, carry_out);
  modport slave (input start, a, b, output busy, done, sum, carry_out);
endinterface

// File: rtl/full_adder_bit.sv
// full_adder_bit: combinational 1-bit full adder from two half adders (a, b, cin -> s, cout)
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p, g, t;
  assign p = a ^ b;
  assign g = a & b;
  assign s = p ^ cin;
  assign t = p & cin;
  assign cout = g | t;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder over WIDTH cycles; ports clk, rst_n (async active-low), bus (slave: start/a/b in, busy/done/sum/carry_out out)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);
  localparam int ACW = WIDTH - 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sa, sb;
  logic [ACW-1:0] acc;
  logic c, s, co, last;
  full_adder_bit u_fa (.a(sa[0]), .b(sb[0]), .cin(c), .s(s), .cout(co));
  assign last = cnt == LAST;
  assign bus.busy = (state == SHIFT) || (state == DONE);
  assign bus.done = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (bus.start ? SHIFT : IDLE) :
              (state == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      c <= 1'b0;
      sa <= '0;
      sb <= '0;
      acc <= '0;
      bus.sum <= '0;
      bus.carry_out <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      sa <= bus.a;
      sb <= bus.b;
      c <= 1'b0;
      cnt <= '0;
    end else if (state == SHIFT) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      c <= co;
      cnt <= cnt + 1'b1;
      acc <= ACW'({s, acc} >> 1);
      if (last) begin
        bus.sum <= {s, acc};
        bus.carry_out <= co;
      end
    end
endmodule
